// File: rtl/i2s_pkg.sv
// Shared constants for the I2S transmit path: word/frame geometry and the
// slot numbers at which requests and loads happen.
package i2s_pkg;

   localparam int WORD_W = 16;
   localparam int SLOTS  = 32;
   localparam int SLOT_W = $clog2(SLOTS);

   typedef logic [SLOT_W-1:0] slot_t;

   localparam slot_t LEFT_REQ   = slot_t'(0);
   localparam slot_t LEFT_LOAD  = slot_t'(1);
   localparam slot_t RIGHT_REQ  = slot_t'(16);
   localparam slot_t RIGHT_LOAD = slot_t'(17);
   localparam slot_t IDLE_SLOT  = slot_t'(31);

   // Slots whose opening bclk fall captures a fresh word from the buffer.
   function automatic logic is_load_slot(input slot_t s);
      return (s == LEFT_LOAD) || (s == RIGHT_LOAD);
   endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles bclk every CLK_DIV clk and flags, one cycle
// ahead, the clk edge on which bclk will rise or fall.
module i2s_bclk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic bclk_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
   logic             bclk_q, bclk_d;
   logic             run, tc;

   assign run = enable && !reset;
   assign tc  = (div_cnt_q == CNT_W'(CLK_DIV - 1));

   always_comb begin
      div_cnt_d = '0;
      bclk_d    = 1'b0;
      if (run) begin
         div_cnt_d = tc ? '0 : div_cnt_q + 1'b1;
         bclk_d    = tc ? ~bclk_q : bclk_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt_q <= '0;
         bclk_q    <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         bclk_q    <= bclk_d;
      end
   end

   // Strobes mark the clk edge that performs the toggle, so the slot logic
   // updates in lockstep with bclk.
   assign rise_o = run && tc && !bclk_q;
   assign fall_o = run && tc && bclk_q;
   assign bclk_o = bclk_q;

endmodule

// File: rtl/i2s_output.sv
// Philips I2S stereo transmitter: pulls 16-bit samples through a ready
// pulse and serialises them MSB first, one bclk after each lrclk edge.
module i2s_output
   import i2s_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [WORD_W-1:0] data,
   output logic              ready,
   output logic              bclk,
   output logic              lrclk,
   output logic              sdata
);

   slot_t             slot_q, slot_d;
   logic [WORD_W-1:0] shift_q, shift_d;
   logic              lrclk_q, lrclk_d;
   logic              sdata_q, sdata_d;
   logic              ready_q, ready_d;
   logic              bclk_fall;
   logic              bclk_rise_unused;

   i2s_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .bclk_o (bclk),
      .rise_o (bclk_rise_unused),
      .fall_o (bclk_fall)
   );

   always_comb begin
      slot_d  = slot_q;
      shift_d = shift_q;
      lrclk_d = lrclk_q;
      sdata_d = sdata_q;
      ready_d = 1'b0;
      if (!enable) begin
         slot_d  = IDLE_SLOT;
         shift_d = '0;
         lrclk_d = 1'b0;
         sdata_d = 1'b0;
      end else if (bclk_fall) begin
         slot_d  = slot_q + 1'b1;
         lrclk_d = slot_d[SLOT_W-1];
         ready_d = (slot_d == LEFT_REQ) || (slot_d == RIGHT_REQ);
         // The right word's LSB spills into slot 0 of the next frame.
         if (is_load_slot(slot_d)) begin
            shift_d = data;
            sdata_d = data[WORD_W-1];
         end else begin
            shift_d = shift_q << 1;
            sdata_d = shift_q[WORD_W-2];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_q  <= IDLE_SLOT;
         shift_q <= '0;
         lrclk_q <= 1'b0;
         sdata_q <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         slot_q  <= slot_d;
         shift_q <= shift_d;
         lrclk_q <= lrclk_d;
         sdata_q <= sdata_d;
         ready_q <= ready_d;
      end
   end

   assign ready = ready_q;
   assign lrclk = lrclk_q;
   assign sdata = sdata_q;

endmodule

// File: tb/tb_i2s_output.sv
// Scoreboard bench for i2s_output: a feeder answers each ready with a word
// and queues its expected bits; a monitor checks timing and serial data.
module tb_i2s_output;

   localparam int C = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [15:0] data;
   logic        ready, bclk, lrclk, sdata;

   i2s_output #(.CLK_DIV(C)) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .data   (data),
      .ready  (ready),
      .bclk   (bclk),
      .lrclk  (lrclk),
      .sdata  (sdata)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   bit          exp_q[$];
   logic [15:0] word_src[$];
   bit          tmo_flag = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Feeder: answers each ready with the next word, then scrambles data
   // right after the load edge to prove it is sampled only there.
   initial begin : feeder
      int          cnt;
      logic [15:0] w;
      cnt  = 0;
      data = '0;
      forever begin
         @(negedge clk);
         if (ready) begin
            w    = (word_src.size() > 0) ? word_src.pop_front() : 16'($urandom);
            data = w;
            for (int b = 15; b >= 0; b--) exp_q.push_back(w[b]);
            cnt = 2 * C;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) data = 16'($urandom);
         end
      end
   end

   // Monitor: a session starts when enable && !reset is first seen; outputs
   // lag that sample by one clk edge.
   initial begin : monitor
      bit prev_act, act, prev_bclk, started, tmo_seen;
      int ncyc, t_start, t_last_rdy, t_last_rise, rdy_idx, rise_idx, n_rise;
      prev_act = 0; prev_bclk = 0; started = 0; tmo_seen = 0;
      ncyc = 0; t_start = 0; t_last_rdy = 0; t_last_rise = 0;
      rdy_idx = 0; rise_idx = 0; n_rise = 0;
      forever begin
         @(negedge clk);
         ncyc++;
         act = enable && !reset;
         if (tmo_flag != tmo_seen) begin
            chk("ready_wait_bound", int'(tmo_flag), 0);
            tmo_seen = tmo_flag;
         end
         if (!prev_act) begin
            chk("idle_outputs", int'({bclk, lrclk, sdata, ready}), 0);
         end else begin
            if (ready) begin
               if (rdy_idx == 0) chk("first_ready_latency", ncyc - t_start, 2 * C);
               else              chk("ready_spacing", ncyc - t_last_rdy, 32 * C);
               chk("ready_lrclk", int'(lrclk), rdy_idx % 2);
               t_last_rdy = ncyc;
               rdy_idx++;
               started = 1;
            end
            if (bclk && !prev_bclk) begin
               if (n_rise == 0) chk("first_rise_latency", ncyc - t_start, C);
               else             chk("bclk_period", ncyc - t_last_rise, 2 * C);
               t_last_rise = ncyc;
               n_rise++;
               if (started) begin
                  chk("lrclk_slot", int'(lrclk), int'((rise_idx % 32) >= 16));
                  if (exp_q.size() == 0) chk("bit_available", exp_q.size(), 1);
                  else                   chk("sdata_bit", int'(sdata), int'(exp_q.pop_front()));
                  rise_idx++;
               end
            end
         end
         if (act && !prev_act) begin
            t_start  = ncyc;
            rdy_idx  = 0;
            n_rise   = 0;
            rise_idx = 0;
            started  = 0;
            exp_q.delete();
            exp_q.push_back(1'b0);  // cleared shift register fills slot 0 of frame one
         end
         if (!act) begin
            exp_q.delete();
            started = 0;
         end
         prev_act  = act;
         prev_bclk = bclk;
      end
   end

   task automatic wait_ready(input bit right);
      int i;
      for (i = 0; i < 200 * C; i++) begin
         @(negedge clk);
         if (ready && (lrclk == right)) break;
      end
      if (i >= 200 * C) tmo_flag = 1'b1;
   endtask

   initial begin : stimulus
      reset  = 1'b1;
      enable = 1'b1;
      word_src.push_back(16'hA5C3);
      word_src.push_back(16'h8001);
      word_src.push_back(16'h7FFF);
      word_src.push_back(16'h8000);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (64 * C * 4) @(posedge clk);

      // Drop enable inside slot 9 of a left word, then restart.
      wait_ready(1'b0);
      repeat (9 * 2 * C) @(posedge clk);
      #1 enable = 1'b0;
      repeat (20) @(posedge clk);
      #1 enable = 1'b1;
      repeat (64 * C * 3) @(posedge clk);

      // Reset inside slot 20 with enable held high.
      wait_ready(1'b1);
      repeat (4 * 2 * C) @(posedge clk);
      #1 reset = 1'b1;
      repeat (5) @(posedge clk);
      #1 reset = 1'b0;
      repeat (64 * C * 3) @(posedge clk);

      #1 enable = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
